// File: rtl/eth_axis_pkg.sv
// Shared types and sizing helpers for the MAC RX store-and-forward frame FIFO.
// Provides the write-side FSM state encoding and the RAM word width helper.
// RAM word layout used throughout: {tlast, tkeep, tdata}.
package eth_axis_pkg;

   typedef enum logic [1:0] {
      WR_IDLE  = 2'd0,
      WR_FRAME = 2'd1,
      WR_DROP  = 2'd2
   } wr_state_t;

   // Width of one buffered beat: tdata + tkeep + tlast.
   function automatic int ram_word_width(input int data_width, input int keep_width);
      return data_width + keep_width + 1;
   endfunction

endpackage

// File: rtl/eth_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
// Latency: read data valid the cycle after rd_en; write visible to a later read.
// Backpressure: none; the caller guarantees it never reads a slot being written.
//   clk      : single clock
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr/rd_data : read port, rd_data holds until the next rd_en
module eth_fifo_sdp_ram #(
   parameter int DEPTH      = 512,
   parameter int WIDTH      = 73,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/eth_axis_rx_frame_fifo.sv
// Store-and-forward frame FIFO behind the MAC RX stream; drops bad and overflowing frames.
// Latency: tlast accepted at edge N -> first beat on m_axis after edge N+2 (empty FIFO, idle output).
// Backpressure: none on s_axis (beats always taken); m_axis honours tready, full rate while ready.
//   rx_clk, rx_rst              : clock, synchronous active-high reset
//   s_axis_*                    : MAC RX beats (tuser = bad-frame flag on the tlast beat)
//   m_axis_*                    : buffered whole frames towards the consumer
//   status_good/bad_frame, status_overflow : one-cycle per-frame outcome pulses
//   status_level                : committed beats not yet handed to the consumer
module eth_axis_rx_frame_fifo
   import eth_axis_pkg::*;
#(
   parameter int DATA_WIDTH     = 64,
   parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
   parameter int DEPTH          = 512,
   parameter int ADDR_WIDTH     = $clog2(DEPTH),
   parameter int DROP_BAD_FRAME = 1
) (
   input  logic                  rx_clk,
   input  logic                  rx_rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  status_good_frame,
   output logic                  status_bad_frame,
   output logic                  status_overflow,
   output logic [ADDR_WIDTH:0]   status_level
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam int WW = ram_word_width(DATA_WIDTH, KEEP_WIDTH);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);

   // ---------------- write side ----------------
   wr_state_t     wr_state;
   logic [PW-1:0] wr_ptr;      // speculative, covers the frame in progress
   logic [PW-1:0] wr_commit;   // end of the last complete good frame
   logic [PW-1:0] rd_ptr;      // advances on m_axis handshakes only
   logic          full;
   logic          wr_en;
   logic          frame_bad;

   // rd_ptr counts beats actually handed out, so beats parked in the output
   // stage still occupy their slot; this also keeps the read of this cycle uncredited.
   assign full      = (wr_ptr - rd_ptr) == PTR_DEPTH;
   assign wr_en     = s_axis_tvalid && (wr_state != WR_DROP) && !full;
   assign frame_bad = (DROP_BAD_FRAME != 0) && s_axis_tuser;

   always_ff @(posedge rx_clk) begin
      if (rx_rst) begin
         wr_state          <= WR_IDLE;
         wr_ptr            <= '0;
         wr_commit         <= '0;
         status_good_frame <= 1'b0;
         status_bad_frame  <= 1'b0;
         status_overflow   <= 1'b0;
      end else begin
         status_good_frame <= 1'b0;
         status_bad_frame  <= 1'b0;
         status_overflow   <= 1'b0;
         if (s_axis_tvalid) begin
            if (wr_state == WR_DROP) begin
               if (s_axis_tlast) begin
                  status_overflow <= 1'b1;
                  wr_state        <= WR_IDLE;
               end
            end else if (full) begin
               // Rewind the partial frame; discard the rest of it.
               wr_ptr <= wr_commit;
               if (s_axis_tlast) begin
                  status_overflow <= 1'b1;
                  wr_state        <= WR_IDLE;
               end else begin
                  wr_state <= WR_DROP;
               end
            end else if (s_axis_tlast) begin
               if (frame_bad) begin
                  wr_ptr           <= wr_commit;
                  status_bad_frame <= 1'b1;
               end else begin
                  wr_ptr            <= wr_ptr + PTR_ONE;
                  wr_commit         <= wr_ptr + PTR_ONE;
                  status_good_frame <= 1'b1;
               end
               wr_state <= WR_IDLE;
            end else begin
               wr_ptr   <= wr_ptr + PTR_ONE;
               wr_state <= WR_FRAME;
            end
         end
      end
   end

   // ---------------- buffer ----------------
   logic [PW-1:0] rd_addr;     // fetch pointer, runs ahead of rd_ptr by the output stage
   logic          rd_en;
   logic [WW-1:0] ram_q;

   eth_fifo_sdp_ram #(
      .DEPTH      (DEPTH),
      .WIDTH      (WW),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (rx_clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
      .wr_data ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
      .rd_en   (rd_en),
      .rd_addr (rd_addr[ADDR_WIDTH-1:0]),
      .rd_data (ram_q)
   );

   // ---------------- read side ----------------
   logic [WW-1:0] out_word;
   logic [WW-1:0] skid_word;
   logic          out_vld;
   logic          skid_vld;
   logic          rd_pend;     // ram_q carries a fetched beat this cycle
   logic          pop;
   logic [1:0]    occ;

   assign pop = out_vld && m_axis_tready;
   assign occ = {1'b0, out_vld} + {1'b0, skid_vld} + {1'b0, rd_pend};
   // Fetch only if the beat will have a register to land in next cycle.
   assign rd_en = (rd_addr != wr_commit) && ((occ - {1'b0, pop}) < 2'd2);

   always_ff @(posedge rx_clk) begin
      if (rx_rst) begin
         out_vld      <= 1'b0;
         skid_vld     <= 1'b0;
         rd_pend      <= 1'b0;
         out_word     <= '0;
         skid_word    <= '0;
         rd_addr      <= '0;
         rd_ptr       <= '0;
         status_level <= '0;
      end else begin
         rd_pend <= rd_en;
         if (rd_en) rd_addr <= rd_addr + PTR_ONE;
         if (pop)   rd_ptr  <= rd_ptr + PTR_ONE;

         // Output register only changes when empty or consumed, keeping it stable under stall.
         if (pop || !out_vld) begin
            if (skid_vld) begin
               out_word <= skid_word;
               out_vld  <= 1'b1;
               skid_vld <= rd_pend;
               if (rd_pend) skid_word <= ram_q;
            end else begin
               out_vld <= rd_pend;
               if (rd_pend) out_word <= ram_q;
            end
         end else if (rd_pend) begin
            skid_word <= ram_q;
            skid_vld  <= 1'b1;
         end

         status_level <= wr_commit - rd_ptr;
      end
   end

   assign m_axis_tvalid = out_vld;
   assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_word;

endmodule

// File: tb/tb_eth_axis_rx_frame_fifo.sv
module tb_eth_axis_rx_frame_fifo;

   localparam int DW    = 64;
   localparam int KW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   localparam int GOOD = 0;
   localparam int BAD  = 1;
   localparam int OVF  = 2;

   typedef struct packed {
      logic          last;
      logic [KW-1:0] keep;
      logic [DW-1:0] data;
   } beat_t;

   logic          rx_clk = 1'b0;
   logic          rx_rst;
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic          s_axis_tvalid;
   logic          s_axis_tlast;
   logic          s_axis_tuser;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic          status_good_frame;
   logic          status_bad_frame;
   logic          status_overflow;
   logic [AW:0]   status_level;

   always #5 rx_clk = ~rx_clk;

   eth_axis_rx_frame_fifo #(
      .DATA_WIDTH     (DW),
      .KEEP_WIDTH     (KW),
      .DEPTH          (DEPTH),
      .DROP_BAD_FRAME (1)
   ) dut (
      .rx_clk            (rx_clk),
      .rx_rst            (rx_rst),
      .s_axis_tdata      (s_axis_tdata),
      .s_axis_tkeep      (s_axis_tkeep),
      .s_axis_tvalid     (s_axis_tvalid),
      .s_axis_tlast      (s_axis_tlast),
      .s_axis_tuser      (s_axis_tuser),
      .m_axis_tdata      (m_axis_tdata),
      .m_axis_tkeep      (m_axis_tkeep),
      .m_axis_tvalid     (m_axis_tvalid),
      .m_axis_tready     (m_axis_tready),
      .m_axis_tlast      (m_axis_tlast),
      .status_good_frame (status_good_frame),
      .status_bad_frame  (status_bad_frame),
      .status_overflow   (status_overflow),
      .status_level      (status_level)
   );

   beat_t sb[$];
   int    vectors     = 0;
   int    miscompares = 0;
   int    exp_good = 0, exp_bad = 0, exp_ovf = 0;
   int    good_seen = 0, bad_seen = 0, ovf_seen = 0;
   int    cyc = 0;
   int    tl_edge = 0;
   bit    lat_arm = 0;
   bit    rand_rdy = 0;
   bit    rst_at_edge = 1;
   bit    prev_vld = 0, prev_rdy = 0;
   beat_t prev_word;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk_data(input int fid, input int b);
      return {16'(fid), 16'(b), 32'hC0DE_0000 + 32'(b * 7 + fid)};
   endfunction

   function automatic logic [KW-1:0] mk_keep(input int fid);
      logic [KW-1:0] k;
      k = 8'hFF;
      return k >> (fid % 8);
   endfunction

   task automatic send_frame(input int fid, input int n, input bit bad, input int outcome);
      beat_t w;
      for (int b = 0; b < n; b++) begin
         @(posedge rx_clk); #1;
         w.last = (b == n - 1);
         w.keep = w.last ? mk_keep(fid) : 8'hFF;
         w.data = mk_data(fid, b);
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = w.data;
         s_axis_tkeep  = w.keep;
         s_axis_tlast  = w.last;
         s_axis_tuser  = w.last && bad;
         if (outcome == GOOD) sb.push_back(w);
      end
      case (outcome)
         GOOD:    exp_good++;
         BAD:     exp_bad++;
         default: exp_ovf++;
      endcase
   endtask

   task automatic idle(input int n);
      @(posedge rx_clk); #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      repeat (n - 1) @(posedge rx_clk);
      #1;
   endtask

   task automatic drain(input int limit);
      for (int i = 0; i < limit && sb.size() > 0; i++) @(posedge rx_clk);
      repeat (4) @(posedge rx_clk);
      #1;
      check("drain_empty", 80'(sb.size()), 80'd0);
   endtask

   task automatic check_pulses(input string tag);
      check({tag, "_good_cnt"}, 80'(good_seen), 80'(exp_good));
      check({tag, "_bad_cnt"},  80'(bad_seen),  80'(exp_bad));
      check({tag, "_ovf_cnt"},  80'(ovf_seen),  80'(exp_ovf));
   endtask

   task automatic cyc_loop();
      forever begin
         @(posedge rx_clk);
         cyc++;
         rst_at_edge = rx_rst;
      end
   endtask

   task automatic rdy_loop();
      forever begin
         @(posedge rx_clk); #1;
         if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic mon_loop();
      beat_t cur, exp;
      forever begin
         @(negedge rx_clk);
         cur = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
         if (status_good_frame) good_seen++;
         if (status_bad_frame)  bad_seen++;
         if (status_overflow)   ovf_seen++;
         if (s_axis_tvalid && s_axis_tlast) tl_edge = cyc + 1;
         if (lat_arm && m_axis_tvalid) begin
            lat_arm = 0;
            check("first_beat_latency", 80'(cyc - tl_edge), 80'd2);
         end
         if (!rst_at_edge && prev_vld && !prev_rdy)
            check("stall_hold", {m_axis_tvalid, cur}, {1'b1, prev_word});
         if (m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_beat: got %0h, expected no beat", cur);
            end else begin
               exp = sb.pop_front();
               check("out_beat", 80'(cur), 80'(exp));
            end
         end
         prev_vld  = m_axis_tvalid;
         prev_rdy  = m_axis_tready;
         prev_word = cur;
      end
   endtask

   int lens[10] = '{1, 9, 3, 7, 2, 8, 5, 4, 6, 1};

   initial begin
      rx_rst        = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      m_axis_tready = 1'b1;
      fork
         cyc_loop();
         mon_loop();
         rdy_loop();
      join_none

      // Reset state
      repeat (3) @(posedge rx_clk);
      @(negedge rx_clk);
      check("rst_tvalid", 80'(m_axis_tvalid), 80'd0);
      check("rst_tlast",  80'(m_axis_tlast),  80'd0);
      check("rst_tdata",  80'(m_axis_tdata),  80'd0);
      check("rst_tkeep",  80'(m_axis_tkeep),  80'd0);
      check("rst_level",  80'(status_level),  80'd0);
      check("rst_pulses", 80'({status_good_frame, status_bad_frame, status_overflow}), 80'd0);
      @(posedge rx_clk); #1;
      rx_rst = 1'b0;
      repeat (2) @(posedge rx_clk);

      // 1: single good 4-beat frame, latency to first output beat
      lat_arm = 1;
      send_frame(1, 4, 0, GOOD);
      idle(1);
      drain(100);
      check_pulses("t1");

      // 2: bad frame discarded, next good frame intact
      send_frame(2, 3, 1, BAD);
      idle(4);
      check("t2_level_after_bad", 80'(status_level), 80'd0);
      check_pulses("t2a");
      send_frame(3, 2, 0, GOOD);
      idle(1);
      drain(100);
      check_pulses("t2b");

      // 3: stalled consumer, fill exactly to DEPTH, fifth frame overflows
      m_axis_tready = 1'b0;
      for (int f = 0; f < 4; f++) send_frame(4 + f, 4, 0, GOOD);
      idle(3);
      check("t3_level_full", 80'(status_level), 80'd16);
      send_frame(8, 4, 0, OVF);
      idle(3);
      check("t3_level_after_ovf", 80'(status_level), 80'd16);
      check_pulses("t3");
      m_axis_tready = 1'b1;
      drain(200);
      check("t3_level_drained", 80'(status_level), 80'd0);

      // 4: oversize frame overflows; exactly-DEPTH frame fits an empty FIFO
      send_frame(9, 20, 0, OVF);
      idle(3);
      check("t4_level_after_ovf", 80'(status_level), 80'd0);
      check_pulses("t4a");
      send_frame(10, 16, 0, GOOD);
      idle(1);
      drain(200);
      check_pulses("t4b");

      // 5: random consumer backpressure over ten frames
      rand_rdy = 1;
      for (int f = 0; f < 10; f++) begin
         send_frame(11 + f, lens[f], 0, GOOD);
         idle(20);
      end
      drain(600);
      rand_rdy = 0;
      m_axis_tready = 1'b1;
      check_pulses("t5");

      // 6: reset mid-frame with one frame buffered
      m_axis_tready = 1'b0;
      send_frame(21, 3, 0, GOOD);
      idle(4);
      check("t6_level_buffered", 80'(status_level), 80'd3);
      @(posedge rx_clk); #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = mk_data(22, 0);
      s_axis_tkeep  = 8'hFF;
      s_axis_tlast  = 1'b0;
      @(posedge rx_clk); #1;
      s_axis_tdata  = mk_data(22, 1);
      rx_rst        = 1'b1;
      @(posedge rx_clk); #1;
      rx_rst        = 1'b0;
      s_axis_tvalid = 1'b0;
      sb.delete();
      @(negedge rx_clk);
      check("t6_tvalid_after_rst", 80'(m_axis_tvalid), 80'd0);
      check("t6_level_after_rst",  80'(status_level),  80'd0);
      m_axis_tready = 1'b1;
      send_frame(23, 4, 0, GOOD);
      idle(1);
      drain(100);
      check_pulses("t6");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
